// File: rtl/div_pkg.sv
// Shared types and defaults for the divider result / BCD conversion stage.
package div_pkg;

    typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

    localparam int unsigned DEF_WIDTH    = 16;
    localparam int unsigned DEF_DIGITS   = 5;
    localparam logic [3:0]  BLANK_NIBBLE = 4'hF;
    localparam int unsigned CNT_W        = $clog2(DEF_WIDTH);

endpackage

// File: rtl/dabble_step.sv
// One double-dabble iteration on a {bcd, binary} vector: add 3 to every
// BCD nibble >= 5, then shift the whole vector left by one.
module dabble_step #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic [4*DIGITS+WIDTH-1:0] din,
    output logic [4*DIGITS+WIDTH-1:0] dout
);

    logic [4*DIGITS+WIDTH-1:0] adj;

    always_comb begin
        adj = din;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (adj[WIDTH+4*i +: 4] >= 4'd5) begin
                adj[WIDTH+4*i +: 4] = adj[WIDTH+4*i +: 4] + 4'd3;
            end
        end
        dout = {adj[4*DIGITS+WIDTH-2:0], 1'b0};
    end

endmodule

// File: rtl/div_result_bcd.sv
// Captures divider results on the rising edge of done, converts quotient and
// remainder to packed BCD one bit per clock, and holds them under valid/ack.
module div_result_bcd
    import div_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  reset_a,
    input  logic [WIDTH-1:0]      quotient,
    input  logic [WIDTH-1:0]      remainder,
    input  logic                  done,
    input  logic                  overflow,
    input  logic                  ack,
    output logic [4*DIGITS-1:0]   quot_bcd,
    output logic [4*DIGITS-1:0]   rem_bcd,
    output logic                  bcd_valid,
    output logic                  err,
    output logic                  busy
);

    localparam int unsigned WORK_W = 4*DIGITS + WIDTH;
    localparam int unsigned CW     = $clog2(WIDTH);

    state_t              state;
    logic                done_d;
    logic                ovf_q;
    logic [CW-1:0]       cnt;
    logic [WORK_W-1:0]   q_work, r_work;
    logic [WORK_W-1:0]   q_next, r_next;
    logic                rise;
    logic                capture;

    dabble_step #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_dabble_q (.din(q_work), .dout(q_next));
    dabble_step #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_dabble_r (.din(r_work), .dout(r_next));

    assign rise      = done & ~done_d;
    // New operands are accepted from IDLE, or from HOLD when the consumer acks on the same edge.
    assign capture   = rise & ((state == IDLE) | ((state == HOLD) & ack));
    assign bcd_valid = (state == HOLD);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            state    <= IDLE;
            done_d   <= 1'b0;
            ovf_q    <= 1'b0;
            cnt      <= '0;
            q_work   <= '0;
            r_work   <= '0;
            quot_bcd <= '0;
            rem_bcd  <= '0;
            err      <= 1'b0;
        end else begin
            done_d <= done;
            if (capture) begin
                q_work <= {{(4*DIGITS){1'b0}}, quotient};
                r_work <= {{(4*DIGITS){1'b0}}, remainder};
                ovf_q  <= overflow;
                cnt    <= '0;
                state  <= CONV;
            end else begin
                unique case (state)
                    CONV: begin
                        // An overflowed capture spends one CONV cycle, then blanks the display.
                        if (ovf_q) begin
                            quot_bcd <= {DIGITS{BLANK_NIBBLE}};
                            rem_bcd  <= {DIGITS{BLANK_NIBBLE}};
                            err      <= 1'b1;
                            state    <= HOLD;
                        end else begin
                            q_work <= q_next;
                            r_work <= r_next;
                            cnt    <= cnt + CW'(1);
                            if (cnt == CW'(WIDTH-1)) begin
                                quot_bcd <= q_next[WORK_W-1 -: 4*DIGITS];
                                rem_bcd  <= r_next[WORK_W-1 -: 4*DIGITS];
                                err      <= 1'b0;
                                state    <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (ack) state <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/div_result_bcd.md
Name: div_result_bcd

Overview:
Downstream stage of the 16-bit sequential divider.
- Captures quotient, remainder and overflow on the rising edge of the divider's done flag.
- Converts both unsigned values to 5-digit packed BCD using iterative shift-add-3 (double dabble), one bit per clock.
- Holds the result for the display/consumer logic under a valid/ack handshake.

Parameters:
WIDTH, 16, operand width of quotient and remainder
DIGITS, 5, BCD digits per operand (4*DIGITS output bits)

Ports:
clk  input  1  system clock, rising edge
reset_a  input  1  asynchronous, active-high reset
quotient  input  WIDTH  divider quotient
remainder  input  WIDTH  divider remainder
done  input  1  divider completion flag, level; only its 0->1 transition is used
overflow  input  1  divider overflow flag, sampled with done
ack  input  1  consumer has taken the result
quot_bcd  output  4*DIGITS  packed BCD of quotient, MS digit in top nibble
rem_bcd  output  4*DIGITS  packed BCD of remainder
bcd_valid  output  1  result stable and ready
err  output  1  captured result came from an overflowed division
busy  output  1  capture/convert/hold in progress

Behaviour:
- Reset (async, reset_a=1): state IDLE, done_d=0, bit counter=0, shadow and working regs=0. Outputs: quot_bcd=0, rem_bcd=0, bcd_valid=0, err=0, busy=0.
- Rise detect: rise = done & ~done_d. done_d is registered every clock in all states.
- States: IDLE, CONV, HOLD. busy=1 in CONV and HOLD.
- IDLE:
  - On rise at edge E0: latch quotient, remainder and overflow into shadow regs; clear working BCD regs; counter=0.
  - If overflow=0: go to CONV.
  - If overflow=1: go to HOLD with quot_bcd=rem_bcd=all-1s (every nibble 4'hF, blank code), err=1, bcd_valid=1, all visible after E1.
- CONV: each edge performs one dabble iteration on both operands in parallel.
  - For every nibble >= 5, add 3.
  - Then shift {bcd, shadow} left by 1, so the shadow MSB enters the BCD LSB.
  - Counter increments by 1.
  - On the iteration with counter==WIDTH-1 (edge E16): load quot_bcd and rem_bcd from the final working values, err=0, bcd_valid=1, go to HOLD.
  - Latency: bcd_valid high 16 clocks after the capture edge.
- HOLD: outputs stable, bcd_valid=1.
  - ack=1 and no rise: go to IDLE; bcd_valid=0 after that edge.
  - ack=1 and rise on the same edge: capture the new operands exactly as in IDLE and go directly to CONV (or HOLD if overflow); bcd_valid=0 after the edge.
  - ack=0: remain in HOLD regardless of rise.
- Dropped events:
  - A rise during CONV, or during HOLD without ack, is dropped; no queuing.
  - ack in IDLE or CONV is ignored.
- Output persistence: quot_bcd, rem_bcd and err keep their last values after returning to IDLE. They change only at conversion completion, at an overflow capture, or on reset.
- done held high: produces a single rise, hence exactly one conversion.
- Reset mid-operation (any state): immediate return to reset values; a partial conversion is discarded.
- Width rule: per operand the working reg is 4*DIGITS BCD + WIDTH shadow bits. The maximum 65535 fits in 5 digits, so there is no truncation.

Decomposition:
- Shared package div_pkg holds:
  - state enum (IDLE, CONV, HOLD)
  - WIDTH and DIGITS defaults
  - BLANK_NIBBLE = 4'hF
  - counter width = clog2(WIDTH)
- Sub-module dabble_step: combinational add-3-per-nibble then shift-left-by-1 on one {bcd, bin} vector. Instantiated twice, once for quotient and once for remainder.
- FSM, edge detect and output registers live in div_result_bcd.

Test Plan:
1. quotient=12345, remainder=678, raise done -> 16 clocks after capture: bcd_valid=1, quot_bcd=20'h12345, rem_bcd=20'h00678, err=0, busy=1.
2. quotient=65535, remainder=0 -> quot_bcd=20'h65535, rem_bcd=20'h00000. Then ack=1 for one clock -> bcd_valid=0, busy=0, and values retained.
3. overflow=1 with done rise -> one clock later: err=1, quot_bcd=rem_bcd=20'hFFFFF, bcd_valid=1. A following normal division clears err at its completion.
4. Hold done high 40 clocks -> exactly one conversion. Pulse done low/high mid-CONV -> ignored, and the result equals the first operands.
5. In HOLD, assert ack on the same edge as a new rise with quotient=9, remainder=1 -> bcd_valid=0 next clock. 16 clocks later: quot_bcd=20'h00009, rem_bcd=20'h00001.
6. Assert reset_a at CONV iteration 7 -> all outputs 0 and state IDLE asynchronously. After release, a new done rise converts correctly.
